// File: rtl/cpu16_pkg.sv
// Shared types and helpers for the cpu16 instruction memory.
package cpu16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } imem_state_t;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int unsigned PAR_MAX_W = 64;

    localparam logic [PAR_MAX_W-1:0] NOP_INSTR = '0;

    // Even-parity bit: XOR of all bits, so {parity, data} always reduces to 0.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/imem_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// The read data register clears on reset so the fetch output starts at zero;
// the storage array itself is never reset.
module imem_dp_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: caller guarantees waddr < DEPTH whenever we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: data is held between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_burst_ctrl.sv
// Instruction memory with a burst-load engine and a 1-cycle registered fetch port.
// Optional build macro PARITY_EN stores an even-parity bit per word and adds
// instr_perr (output) and inject_perr (input).
module imem_burst_ctrl
    import cpu16_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              fetch_stall,
    output logic              addr_err,
`ifdef PARITY_EN
    output logic              instr_perr,
    input  logic              inject_perr,
`endif
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    // DEPTH <= 2**ADDR_W, so the limit always fits in ADDR_W+1 bits.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    imem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              valid_q, aerr_q, oor_q;
    logic [ADDR_W:0]   wr_addr;
    logic              wr_in_range, load_xfer;
    logic              fetch_acc, fetch_in_range;
    logic              ram_we, ram_re;
    logic [MEM_W-1:0]  ram_wdata, ram_rdata;

    // Write address is widened by one bit so a burst past the top never wraps to 0.
    assign wr_addr     = {1'b0, base_q} + (ADDR_W + 1)'(cnt_q);
    assign wr_in_range = wr_addr < DEPTH_LIM;
    assign load_ready  = (state_q == LOAD);
    assign load_busy   = (state_q != IDLE);
    assign load_done   = (state_q == DONE);
    assign load_err    = err_q;
    assign fetch_stall = load_busy;
    assign load_xfer   = load_valid & load_ready;

    // State and burst bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic for the burst loader.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    base_d  = load_base;
                    len_d   = load_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_xfer) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (!wr_in_range) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Out-of-range words are consumed but dropped; reset suppresses a write in flight.
    assign ram_we = rst_n & load_xfer & wr_in_range;
`ifdef PARITY_EN
    assign ram_wdata = {even_parity(PAR_MAX_W'(load_data)) ^ inject_perr, load_data};
`else
    assign ram_wdata = load_data;
`endif

    assign fetch_acc      = fetch_en & ~fetch_stall;
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_LIM;
    assign ram_re         = rst_n & fetch_acc & fetch_in_range;

    imem_dp_ram #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (wr_addr[AW-1:0]),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fetch_addr[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Fetch status registers; oor_q selects the NOP and holds until the next accepted fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            aerr_q  <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            valid_q <= fetch_acc;
            aerr_q  <= fetch_acc & ~fetch_in_range;
            if (fetch_acc) begin
                oor_q <= ~fetch_in_range;
            end
        end
    end

    assign instr_out   = oor_q ? DATA_W'(NOP_INSTR) : ram_rdata[DATA_W-1:0];
    assign instr_valid = valid_q;
    assign addr_err    = aerr_q;
`ifdef PARITY_EN
    assign instr_perr  = valid_q & ~oor_q & (^ram_rdata);
`endif

endmodule

// File: tb/tb_imem_burst_ctrl.sv
// Directed self-checking bench for imem_burst_ctrl (default parameters).
// Define PARITY_EN to also exercise the parity path.
module tb_imem_burst_ctrl;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] fetch_addr;
    logic [15:0] instr_out;
    logic        instr_valid, fetch_stall, addr_err;
    logic        load_start;
    logic [15:0] load_base, load_len, load_data;
    logic        load_valid, load_ready, load_busy, load_done, load_err;
`ifdef PARITY_EN
    logic        instr_perr;
    logic        inject_perr;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int done_pulses = 0;
    int ready_seen = 0;
    int done_snap, ready_snap;

    always #5 clk = ~clk;

    imem_burst_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
        .addr_err    (addr_err),
`ifdef PARITY_EN
        .instr_perr  (instr_perr),
        .inject_perr (inject_perr),
`endif
        .load_start  (load_start),
        .load_base   (load_base),
        .load_len    (load_len),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (load_done === 1'b1) done_pulses++;
        if (load_ready === 1'b1) ready_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start edge, then len words d0, d0+1, ... optionally with an idle cycle before each.
    task automatic load_burst(input logic [15:0] base, input logic [15:0] len,
                              input logic [15:0] d0, input bit gap);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            if (gap) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = d0 + 16'(i);
            tick();
        end
        load_valid = 1'b0;
    endtask

    // One fetch cycle; leaves fetch_en high so consecutive calls are back-to-back.
    task automatic fetch_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        tick();
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_data"}, 32'(instr_out), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0; load_start = 1'b0;
        load_base = '0; load_len = '0; load_data = '0; load_valid = 1'b0;
`ifdef PARITY_EN
        inject_perr = 1'b0;
`endif

        // 1: reset with inputs toggling
        for (int i = 0; i < 2; i++) begin
            fetch_en   = ~fetch_en;
            load_start = ~load_start;
            load_valid = ~load_valid;
            load_len   = 16'(i + 3);
            tick();
        end
        check("rst_instr_out", 32'(instr_out), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_stall", 32'(fetch_stall), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        rst_n = 1'b1; fetch_en = 1'b0; load_start = 1'b0; load_valid = 1'b0;
        tick();

        // 2: gapped burst of 4 words at 0x10
        done_snap = done_pulses;
        load_burst(16'h0010, 16'd4, 16'hA001, 1'b1);
        check("t2_done_now", 32'(load_done), 32'd1);
        check("t2_no_early_done", 32'(done_pulses - done_snap), 32'd0);
        check("t2_ready_in_done", 32'(load_ready), 32'd0);
        tick();
        check("t2_done_once", 32'(done_pulses - done_snap), 32'd1);
        check("t2_done_low", 32'(load_done), 32'd0);
        check("t2_idle", 32'(load_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            fetch_check($sformatf("t2_fetch%0d", i), 16'h0010 + 16'(i), 16'hA001 + 16'(i));
        end
        fetch_en = 1'b0;
        tick();
        check("t2_valid_off", 32'(instr_valid), 32'd0);
        check("t2_hold", 32'(instr_out), 32'hA004);

        // 3: burst running past the top of memory
        load_burst(16'(DEPTH - 2), 16'd4, 16'hB001, 1'b0);
        check("t3_err_set", 32'(load_err), 32'd1);
        tick();
        check("t3_err_sticky", 32'(load_err), 32'd1);
        fetch_check("t3_top0", 16'(DEPTH - 2), 16'hB001);
        fetch_check("t3_top1", 16'(DEPTH - 1), 16'hB002);
        check("t3_no_aerr", 32'(addr_err), 32'd0);
        fetch_check("t3_oor", 16'(DEPTH + 5), 16'h0000);
        check("t3_aerr", 32'(addr_err), 32'd1);
        fetch_en = 1'b0;
        tick();
        check("t3_aerr_pulse", 32'(addr_err), 32'd0);
        check("t3_nop_hold", 32'(instr_out), 32'h0000);

        // 4: zero-length burst; also the start that clears load_err
        done_snap  = done_pulses;
        ready_snap = ready_seen;
        load_start = 1'b1; load_base = 16'h0010; load_len = 16'd0;
        tick();
        load_start = 1'b0;
        check("t4_err_clr", 32'(load_err), 32'd0);
        check("t4_done", 32'(load_done), 32'd1);
        tick();
        check("t4_done_low", 32'(load_done), 32'd0);
        check("t4_idle", 32'(load_busy), 32'd0);
        check("t4_done_once", 32'(done_pulses - done_snap), 32'd1);
        check("t4_no_ready", 32'(ready_seen - ready_snap), 32'd0);
        fetch_check("t4_mem_kept", 16'h0010, 16'hA001);
        fetch_en = 1'b0;
        tick();

        // 5: fetch held high across a burst that is aborted by reset
        load_burst(16'h0020, 16'd4, 16'hC001, 1'b0);
        tick();
        done_snap  = done_pulses;
        fetch_en   = 1'b1; fetch_addr = 16'h0030;
        load_start = 1'b1; load_base = 16'h0020; load_len = 16'd4;
        tick();
        load_start = 1'b0;
        check("t5_start_fetch_served", 32'(instr_valid), 32'd1);
        check("t5_stall", 32'(fetch_stall), 32'd1);
        load_valid = 1'b1; load_data = 16'hD001;
        tick();
        check("t5_valid0_w0", 32'(instr_valid), 32'd0);
        load_data = 16'hD002;
        tick();
        check("t5_valid0_w1", 32'(instr_valid), 32'd0);
        check("t5_busy", 32'(load_busy), 32'd1);
        rst_n = 1'b0; load_data = 16'hD003;
        tick();
        check("t5_rst_busy", 32'(load_busy), 32'd0);
        check("t5_rst_stall", 32'(fetch_stall), 32'd0);
        check("t5_rst_valid", 32'(instr_valid), 32'd0);
        rst_n = 1'b1; load_valid = 1'b0; fetch_en = 1'b0;
        tick();
        tick();
        check("t5_no_done", 32'(done_pulses - done_snap), 32'd0);
        check("t5_idle", 32'(load_busy), 32'd0);
        fetch_check("t5_w0", 16'h0020, 16'hD001);
        fetch_check("t5_w1", 16'h0021, 16'hD002);
        fetch_check("t5_w2", 16'h0022, 16'hC003);
        fetch_check("t5_w3", 16'h0023, 16'hC004);
        fetch_en = 1'b0;
        tick();

`ifdef PARITY_EN
        // 6: parity error injection
        inject_perr = 1'b1;
        load_burst(16'h0040, 16'd1, 16'h1234, 1'b0);
        inject_perr = 1'b0;
        tick();
        load_burst(16'h0041, 16'd1, 16'h1234, 1'b0);
        tick();
        fetch_check("t6_bad", 16'h0040, 16'h1234);
        check("t6_perr_set", 32'(instr_perr), 32'd1);
        fetch_check("t6_good", 16'h0041, 16'h1234);
        check("t6_perr_clr", 32'(instr_perr), 32'd0);
        fetch_en = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
